// File: rtl/dru_phase_ctrl.sv
// dru_phase_ctrl: 4x-oversampling data-recovery phase controller.
// Histograms transition positions per sampling phase over fixed windows and
// steers the pick-off phase to the one opposite the densest edge phase, with
// hysteresis. Emits two recovered bits per clock plus lock/slip status.

// Per-phase saturating edge counter with end-of-window snapshot.
module dru_phase_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             i_run,
  input  logic             i_term,
  input  logic [1:0]       i_edges,
  output logic [CNT_W-1:0] o_snap
);
  localparam logic [CNT_W:0] MAX = {1'b0, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_snap;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_sat;

  // one extra bit so the saturation test sees the carry
  assign w_sum  = {1'b0, r_cnt} + {{(CNT_W-1){1'b0}}, i_edges};
  assign w_sat  = (w_sum > MAX) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
  assign o_snap = r_snap;

  // accumulate; on the terminal cycle fold this cycle's edges into the snapshot
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt  <= '0;
      r_snap <= '0;
    end else if (!i_run) begin
      r_cnt  <= '0;
    end else if (i_term) begin
      r_snap <= w_sat;
      r_cnt  <= '0;
    end else begin
      r_cnt  <= w_sat;
    end
  end
endmodule

module dru_phase_ctrl #(
  parameter int WIN_CYCLES = 64,
  parameter int CNT_W      = 8,
  parameter int MIN_EDGES  = 16,
  parameter int HYST       = 2
) (
  input  logic       clk,
  input  logic       aresetn,
  input  logic       enable,
  input  logic [7:0] sample_window,
  output logic [1:0] data_out,
  output logic       data_valid,
  output logic [1:0] phase_sel,
  output logic       locked,
  output logic       slip,
  output logic       slip_dir
);
  localparam int WCW = $clog2(WIN_CYCLES);
  localparam int PW  = $clog2(HYST + 1);
  localparam int TW  = CNT_W + 2;

  logic [7:0]            r_s;
  logic                  r_sp;
  logic [WCW-1:0]        r_wcnt;
  logic                  r_dec;
  logic [PW-1:0]         r_pend;

  logic [7:0]            w_e;
  logic [3:0][1:0]       w_pe;
  logic [3:0][CNT_W-1:0] w_snap;
  logic                  w_term;
  logic [TW-1:0]         w_total;
  logic [1:0]            w_pmax;
  logic [1:0]            w_cand;
  logic [1:0]            w_dist;
  logic [1:0]            w_next;
  logic                  w_qual;

  // sample 0 compares against the last sample of the previous window
  assign w_e    = r_s ^ {r_s[6:0], r_sp};
  assign w_term = (r_wcnt == WCW'(WIN_CYCLES - 1));

  genvar gp;
  generate
    for (gp = 0; gp < 4; gp++) begin : g_ph
      assign w_pe[gp] = {1'b0, w_e[gp]} + {1'b0, w_e[gp+4]};
      dru_phase_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .aresetn (aresetn),
        .i_run   (enable),
        .i_term  (w_term),
        .i_edges (w_pe[gp]),
        .o_snap  (w_snap[gp])
      );
    end
  endgenerate

  assign w_total = {2'b00, w_snap[0]} + {2'b00, w_snap[1]}
                 + {2'b00, w_snap[2]} + {2'b00, w_snap[3]};
  assign w_qual  = (w_total >= TW'(MIN_EDGES));

  // densest edge phase; strict compare keeps the lowest index on ties
  always_comb begin
    w_pmax = 2'd0;
    for (int p = 1; p < 4; p++)
      if (w_snap[p] > w_snap[w_pmax]) w_pmax = 2'(p);
  end

  // sample opposite the edges; distance 2 breaks toward +1
  assign w_cand = w_pmax + 2'd2;
  assign w_dist = w_cand - phase_sel;
  assign w_next = phase_sel + ((w_dist == 2'd3) ? 2'd3 : 2'd1);

  // input stage, free-running regardless of enable
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_s  <= '0;
      r_sp <= 1'b0;
    end else begin
      r_s  <= sample_window;
      r_sp <= r_s[7];
    end
  end

  // window counter; r_dec flags the cycle holding a fresh snapshot
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_wcnt <= '0;
      r_dec  <= 1'b0;
    end else if (!enable) begin
      r_wcnt <= '0;
      r_dec  <= 1'b0;
    end else begin
      r_dec  <= w_term;
      r_wcnt <= w_term ? '0 : r_wcnt + 1'b1;
    end
  end

  // phase decision with hysteresis and wrap reporting
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      phase_sel <= 2'd0;
      locked    <= 1'b0;
      slip      <= 1'b0;
      slip_dir  <= 1'b0;
      r_pend    <= '0;
    end else begin
      slip <= 1'b0;
      if (!enable) begin
        r_pend <= '0;
      end else if (r_dec) begin
        if (!w_qual) begin
          locked <= 1'b0;
          r_pend <= '0;
        end else if (w_cand == phase_sel) begin
          locked <= 1'b1;
          r_pend <= '0;
        end else if (r_pend == PW'(HYST - 1)) begin
          phase_sel <= w_next;
          locked    <= 1'b0;
          r_pend    <= '0;
          if (phase_sel == 2'd3 && w_next == 2'd0) begin
            slip     <= 1'b1;
            slip_dir <= 1'b1;
          end else if (phase_sel == 2'd0 && w_next == 2'd3) begin
            slip     <= 1'b1;
            slip_dir <= 1'b0;
          end
        end else begin
          r_pend <= r_pend + 1'b1;
        end
      end
    end
  end

  // recovered bits picked at the current phase from each UI
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      data_out   <= 2'b00;
      data_valid <= 1'b0;
    end else begin
      data_out   <= {r_s[{1'b1, phase_sel}], r_s[{1'b0, phase_sel}]};
      data_valid <= enable;
    end
  end
endmodule

// File: tb/tb_dru_phase_ctrl.sv
// Bench for dru_phase_ctrl: behavioural model checked every cycle, directed
// phase-steering scenarios with literal expectations, then randomized traffic.
module tb_dru_phase_ctrl;
  localparam int W  = 16;
  localparam int CW = 5;
  localparam int ME = 16;
  localparam int HY = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic       clk, aresetn, enable;
  logic [7:0] sample_window;
  logic [1:0] data_out, phase_sel;
  logic       data_valid, locked, slip, slip_dir;

  dru_phase_ctrl #(.WIN_CYCLES(W), .CNT_W(CW), .MIN_EDGES(ME), .HYST(HY)) dut (
    .clk(clk), .aresetn(aresetn), .enable(enable), .sample_window(sample_window),
    .data_out(data_out), .data_valid(data_valid), .phase_sel(phase_sel),
    .locked(locked), .slip(slip), .slip_dir(slip_dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_s;
  logic       m_sp;
  int         m_hist[4], m_snap[4];
  int         m_wc, m_pend;
  bit         m_dec;
  logic [1:0] mo_dout, mo_ps;
  logic       mo_dv, mo_lk, mo_slip, mo_sdir;

  task automatic m_reset();
    m_s = '0; m_sp = 1'b0; m_wc = 0; m_pend = 0; m_dec = 0;
    for (int p = 0; p < 4; p++) begin m_hist[p] = 0; m_snap[p] = 0; end
    mo_dout = '0; mo_ps = '0; mo_dv = 0; mo_lk = 0; mo_slip = 0; mo_sdir = 0;
  endtask

  task automatic m_edge(input logic [7:0] win, input logic en);
    int ed[4];
    int tot, best, cand, ps, nps;
    logic prev;
    for (int p = 0; p < 4; p++) ed[p] = 0;
    // transitions in the serial sample stream, binned by position mod 4
    prev = m_sp;
    for (int i = 0; i < 8; i++) begin
      if (m_s[i] != prev) ed[i % 4]++;
      prev = m_s[i];
    end
    ps = int'(mo_ps);
    mo_dout = {m_s[4 + ps], m_s[ps]};
    mo_dv = en;
    mo_slip = 0;
    if (en && m_dec) begin
      tot = 0; best = 0;
      for (int p = 0; p < 4; p++) begin
        tot += m_snap[p];
        if (m_snap[p] > m_snap[best]) best = p;
      end
      cand = (best + 2) % 4;
      if (tot < ME) begin
        mo_lk = 0; m_pend = 0;
      end else if (cand == ps) begin
        mo_lk = 1; m_pend = 0;
      end else if (m_pend + 1 == HY) begin
        nps = (((cand - ps + 4) % 4) == 3) ? (ps + 3) % 4 : (ps + 1) % 4;
        if (ps == 3 && nps == 0) begin mo_slip = 1; mo_sdir = 1; end
        if (ps == 0 && nps == 3) begin mo_slip = 1; mo_sdir = 0; end
        mo_ps = 2'(nps); m_pend = 0; mo_lk = 0;
      end else begin
        m_pend++;
      end
    end
    if (en) begin
      for (int p = 0; p < 4; p++) m_hist[p] = (m_hist[p] + ed[p] > MAXC) ? MAXC : m_hist[p] + ed[p];
      m_wc++;
      if (m_wc == W) begin
        for (int p = 0; p < 4; p++) begin m_snap[p] = m_hist[p]; m_hist[p] = 0; end
        m_wc = 0; m_dec = 1;
      end else m_dec = 0;
    end else begin
      for (int p = 0; p < 4; p++) m_hist[p] = 0;
      m_wc = 0; m_pend = 0; m_dec = 0;
    end
    m_sp = m_s[7];
    m_s = win;
  endtask

  // per-cycle compare, sampled 1 time unit after the active edge
  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      if (!aresetn) m_reset();
      else m_edge(sample_window, enable);
      #1;
      chk("data_out", data_out, mo_dout);
      chk("data_valid", data_valid, mo_dv);
      chk("phase_sel", phase_sel, mo_ps);
      chk("locked", locked, mo_lk);
      chk("slip", slip, mo_slip);
      if (mo_slip) chk("slip_dir", slip_dir, mo_sdir);
    end
  end

  // ---------------- stimulus ----------------
  logic g_prev = 1'b1;

  // t=0..3: edges at phase t (dense: every UI toggles); t=4 fully random; t=5 all ones
  task automatic gen(input int t, input bit dense, input int noise, output logic [7:0] w);
    logic nb;
    int idx;
    w = '0;
    if (t == 4) w = 8'($urandom);
    else if (t == 5) begin w = 8'hFF; g_prev = 1'b1; end
    else begin
      for (int j = 0; j < 2; j++) begin
        nb = dense ? ~g_prev : 1'($urandom_range(0, 1));
        for (int k = 0; k < 4; k++) w[4*j + k] = (k < t) ? g_prev : nb;
        g_prev = nb;
      end
    end
    if (int'($urandom_range(0, 99)) < noise) begin
      idx = $urandom_range(0, 7);
      w[idx] = ~w[idx];
    end
  endtask

  task automatic cyc(input logic [7:0] w, input logic en);
    sample_window = w;
    enable = en;
    @(negedge clk);
  endtask

  task automatic run(input int t, input int n, input logic en);
    logic [7:0] w;
    for (int i = 0; i < n; i++) begin gen(t, 1'b1, 0, w); cyc(w, en); end
  endtask

  task automatic go(input int t, input int target, input int bound, output int slips, output int dir);
    logic [7:0] w;
    int k;
    slips = 0; dir = -1; k = 0;
    while (int'(phase_sel) != target && k < bound) begin
      gen(t, 1'b1, 0, w);
      cyc(w, 1'b1);
      if (slip === 1'b1) begin slips++; dir = int'(slip_dir); end
      k++;
    end
    chk($sformatf("reach_ps%0d", target), phase_sel, target);
  endtask

  initial begin
    int sl, dr, n, t, noise;
    bit dense;
    logic [7:0] w;
    aresetn = 1'b0; enable = 1'b0; sample_window = '0;
    repeat (2) @(negedge clk);
    chk("rst_ps", phase_sel, 0);
    chk("rst_locked", locked, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_slip", slip, 0);
    aresetn = 1'b1;

    // converge from phase 0 with edges at phase 0
    g_prev = 1'b1;
    run(0, 2, 1'b0);
    run(0, 2*W + 1, 1'b1);
    chk("conv_ps1", phase_sel, 1);
    chk("model_ps1", mo_ps, 1);
    run(0, 2*W, 1'b1);
    chk("conv_ps2", phase_sel, 2);
    run(0, W, 1'b1);
    chk("conv_lock", locked, 1);
    chk("conv_dout", data_out, 2'b10);
    chk("model_dout", mo_dout, 2'b10);

    // async reset mid-window
    run(0, W/2, 1'b1);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_ps", phase_sel, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_dv", data_valid, 0);
    chk("mid_rst_dout", data_out, 0);
    enable = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;

    // first decision lands W+1 cycles after enable
    run(2, 2, 1'b0);
    run(2, W, 1'b1);
    chk("first_dec_early", locked, 0);
    run(2, 1, 1'b1);
    chk("first_dec_lock", locked, 1);
    chk("first_dec_ps", phase_sel, 0);

    // steering and wraps
    go(3, 1, 6*W, sl, dr);
    chk("step01_noslip", sl, 0);
    go(1, 3, 8*W, sl, dr);
    chk("step13_noslip", sl, 0);
    go(2, 0, 6*W, sl, dr);
    chk("wrap30_slips", sl, 1);
    chk("wrap30_dir", dr, 1);
    go(1, 3, 6*W, sl, dr);
    chk("wrap03_slips", sl, 1);
    chk("wrap03_dir", dr, 0);

    // unqualified window drops lock, holds phase
    go(0, 2, 6*W, sl, dr);
    run(0, 2*W, 1'b1);
    chk("unq_pre_lock", locked, 1);
    run(5, 2*W, 1'b1);
    chk("unq_lock", locked, 0);
    chk("unq_ps", phase_sel, 2);

    // single disagreeing window is absorbed by hysteresis
    run(0, 2*W, 1'b1);
    chk("hyst_pre_lock", locked, 1);
    run(1, W, 1'b1);
    run(0, 3*W, 1'b1);
    chk("hyst_lock", locked, 1);
    chk("hyst_ps", phase_sel, 2);

    // saturating phase-1 edges pull to phase 3, then enable drop
    go(1, 3, 6*W, sl, dr);
    chk("sat_noslip", sl, 0);
    run(1, 2*W, 1'b1);
    chk("sat_lock", locked, 1);
    run(1, W/2, 1'b1);
    run(1, 1, 1'b0);
    chk("en_drop_dv", data_valid, 0);
    chk("en_drop_ps", phase_sel, 3);
    run(1, 3, 1'b0);
    run(0, W + 1, 1'b1);
    chk("en_resume_ps", phase_sel, 3);

    // randomized traffic
    for (int seg = 0; seg < 40; seg++) begin
      t = $urandom_range(0, 5);
      if (t == 5 && $urandom_range(0, 1) == 1) t = 4;
      dense = 1'($urandom_range(0, 1));
      noise = $urandom_range(0, 30);
      n = $urandom_range(W, 5*W);
      for (int i = 0; i < n; i++) begin
        gen(t, dense, noise, w);
        if ($urandom_range(0, 499) == 0) begin
          aresetn = 1'b0;
          cyc(w, 1'b0);
          aresetn = 1'b1;
        end else begin
          cyc(w, ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1);
        end
      end
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
